// File: rtl/core_dmem_pkg.sv
// Shared encodings and helpers for the core data-memory responder.
package core_dmem_pkg;

    // Load kinds carried on read_type.
    localparam logic [2:0] RT_LB   = 3'b000;
    localparam logic [2:0] RT_LH   = 3'b001;
    localparam logic [2:0] RT_LW   = 3'b010;
    localparam logic [2:0] RT_LD   = 3'b011;
    localparam logic [2:0] RT_LBU  = 3'b100;
    localparam logic [2:0] RT_LHU  = 3'b101;
    localparam logic [2:0] RT_LWU  = 3'b110;
    localparam logic [2:0] RT_RSVD = 3'b111;

    // Store kinds carried on write_type.
    localparam logic [1:0] WT_SB = 2'b00;
    localparam logic [1:0] WT_SH = 2'b01;
    localparam logic [1:0] WT_SW = 2'b10;
    localparam logic [1:0] WT_SD = 2'b11;

    // One enable bit per byte of a 64-bit word.
    localparam int BE_W = 8;

    // How the extracted load lane is widened to XLEN.
    typedef enum logic [1:0] {
        EXT_RAW  = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_ZERO = 2'b10
    } ext_sel_e;

    // Offset bits that must be zero for an access of the given size code.
    function automatic logic [2:0] align_mask(input logic [1:0] size_code);
        logic [2:0] mask;
        case (size_code)
            2'b00:   mask = 3'b000;
            2'b01:   mask = 3'b001;
            2'b10:   mask = 3'b011;
            2'b11:   mask = 3'b111;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

    // Byte-enable pattern for an access of the given size code at offset 0.
    function automatic logic [BE_W-1:0] size_be(input logic [1:0] size_code);
        logic [BE_W-1:0] be;
        case (size_code)
            2'b00:   be = 8'h01;
            2'b01:   be = 8'h03;
            2'b10:   be = 8'h0F;
            2'b11:   be = 8'hFF;
            default: be = 8'h00;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/core_dmem_lane.sv
// Byte-lane steering: store byte-enable/data shifting and load extract/extend.
module core_dmem_lane
    import core_dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      read_type,
    input  logic [1:0]      write_type,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] raw_word,
    output logic [BE_W-1:0] st_be,
    output logic [XLEN-1:0] st_data,
    output logic            st_misalign,
    output logic [XLEN-1:0] ld_data,
    output logic            ld_misalign
);

    logic [5:0]  shamt_s;
    logic [31:0] lane_s;
    ext_sel_e    ext_sel_s;

    assign shamt_s = {offset, 3'b000};

    // Store side: alignment check, byte-enable and lane-shifted data.
    always_comb begin
        st_misalign = |(offset & align_mask(write_type));
        st_data     = wdata << shamt_s;
        if (st_misalign) begin
            st_be = 8'h00;
        end else begin
            st_be = size_be(write_type) << offset;
        end
    end

    // Load side: alignment check, lane extraction and sign/zero extension.
    always_comb begin
        ld_misalign = (read_type == RT_RSVD) || (|(offset & align_mask(read_type[1:0])));
        lane_s      = 32'(raw_word >> shamt_s);
        if (read_type == RT_LD) begin
            ext_sel_s = EXT_RAW;
        end else if (read_type[2]) begin
            ext_sel_s = EXT_ZERO;
        end else begin
            ext_sel_s = EXT_SIGN;
        end
        case (read_type[1:0])
            2'b00: begin
                if (ext_sel_s == EXT_SIGN) begin
                    ld_data = {{(XLEN-8){lane_s[7]}}, lane_s[7:0]};
                end else begin
                    ld_data = {{(XLEN-8){1'b0}}, lane_s[7:0]};
                end
            end
            2'b01: begin
                if (ext_sel_s == EXT_SIGN) begin
                    ld_data = {{(XLEN-16){lane_s[15]}}, lane_s[15:0]};
                end else begin
                    ld_data = {{(XLEN-16){1'b0}}, lane_s[15:0]};
                end
            end
            2'b10: begin
                if (ext_sel_s == EXT_SIGN) begin
                    ld_data = {{(XLEN-32){lane_s[31]}}, lane_s[31:0]};
                end else begin
                    ld_data = {{(XLEN-32){1'b0}}, lane_s[31:0]};
                end
            end
            2'b11: begin
                if (ext_sel_s == EXT_RAW) begin
                    ld_data = raw_word;
                end else begin
                    ld_data = {XLEN{1'b0}};
                end
            end
            default: ld_data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/core_dmem.sv
// Data-memory responder: combinational loads, buffered stores with forwarding,
// sticky misalignment capture.
module core_dmem
    import core_dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int XLEN       = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      read_type,
    input  logic [1:0]      write_type,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_rdata,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr,
    output logic            wbuf_valid
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [XLEN-1:0]       mem_r [DEPTH];

    logic [DEPTH_LOG2-1:0] idx_s;
    logic [2:0]            offset_s;
    logic                  unused_addr_s;

    logic                  wbuf_valid_r;
    logic [DEPTH_LOG2-1:0] wbuf_idx_r;
    logic [XLEN-1:0]       wbuf_data_r;
    logic [BE_W-1:0]       wbuf_be_r;
    logic                  misalign_err_r;
    logic [XLEN-1:0]       misalign_addr_r;

    logic [XLEN-1:0]       raw_s;
    logic [XLEN-1:0]       merged_s;
    logic                  hit_s;
    logic [BE_W-1:0]       st_be_s;
    logic [XLEN-1:0]       st_data_s;
    logic                  st_mis_s;
    logic [XLEN-1:0]       ld_data_s;
    logic                  ld_mis_s;
    logic                  st_ok_s;
    logic                  any_mis_s;

    // Upper address bits wrap the array and are intentionally ignored.
    assign idx_s         = mem_addr[DEPTH_LOG2+2:3];
    assign offset_s      = mem_addr[2:0];
    assign unused_addr_s = ^mem_addr[XLEN-1:DEPTH_LOG2+3];

    core_dmem_lane #(.XLEN(XLEN)) u_lane (
        .read_type   (read_type),
        .write_type  (write_type),
        .offset      (offset_s),
        .wdata       (mem_wdata),
        .raw_word    (merged_s),
        .st_be       (st_be_s),
        .st_data     (st_data_s),
        .st_misalign (st_mis_s),
        .ld_data     (ld_data_s),
        .ld_misalign (ld_mis_s)
    );

    assign st_ok_s   = mem_write && !st_mis_s;
    assign any_mis_s = (mem_read && ld_mis_s) || (mem_write && st_mis_s);

    // Merge the pending buffered store into the addressed word (forwarding).
    always_comb begin
        raw_s    = mem_r[idx_s];
        hit_s    = wbuf_valid_r && (wbuf_idx_r == idx_s);
        merged_s = raw_s;
        for (int b = 0; b < BE_W; b++) begin
            if (hit_s && wbuf_be_r[b]) begin
                merged_s[b*8 +: 8] = wbuf_data_r[b*8 +: 8];
            end else begin
                merged_s[b*8 +: 8] = raw_s[b*8 +: 8];
            end
        end
    end

    // Load result: zero when idle or when the load is misaligned.
    always_comb begin
        if (mem_read && !ld_mis_s) begin
            mem_rdata = ld_data_s;
        end else begin
            mem_rdata = {XLEN{1'b0}};
        end
    end

    // Commit the buffered store into the array under its byte-enable.
    always_ff @(posedge clk) begin
        if (wbuf_valid_r) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wbuf_be_r[b]) begin
                    mem_r[wbuf_idx_r][b*8 +: 8] <= wbuf_data_r[b*8 +: 8];
                end
            end
        end
    end

    // Write buffer: capture each aligned store, drain after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbuf_valid_r <= 1'b0;
            wbuf_idx_r   <= {DEPTH_LOG2{1'b0}};
            wbuf_data_r  <= {XLEN{1'b0}};
            wbuf_be_r    <= 8'h00;
        end else if (st_ok_s) begin
            wbuf_valid_r <= 1'b1;
            wbuf_idx_r   <= idx_s;
            wbuf_data_r  <= st_data_s;
            wbuf_be_r    <= st_be_s;
        end else begin
            wbuf_valid_r <= 1'b0;
        end
    end

    // Sticky capture of the first misaligned access after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err_r  <= 1'b0;
            misalign_addr_r <= {XLEN{1'b0}};
        end else if (any_mis_s && !misalign_err_r) begin
            misalign_err_r  <= 1'b1;
            misalign_addr_r <= mem_addr;
        end
    end

    assign misalign_err  = misalign_err_r;
    assign misalign_addr = misalign_addr_r;
    assign wbuf_valid    = wbuf_valid_r;

endmodule
